// File: rtl/waves_pkg.sv
// Shared types and constants for the wave generator datapath.
package waves_pkg;

  typedef logic signed [15:0] sample_t;

  localparam int unsigned FRAME_BITS          = 32;
  localparam int unsigned I2S_CLK_DIV_DEFAULT = 8;

endpackage

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: divides clk down to SCK and flags each SCK falling edge.
// en low holds the divider and SCK in their reset state.
module i2s_sck_gen
  import waves_pkg::*;
#(
  parameter int unsigned CLK_DIV = I2S_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic i2s_sck,
  output logic fall_evt
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic             wrap;

  assign wrap = (div_cnt == CNT_MAX);

  // Strobe coincides with the clk edge on which SCK goes 1->0.
  assign fall_evt = rst_n & en & wrap & i2s_sck;

  // Divider counter and SCK toggle register.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      i2s_sck <= ~i2s_sck;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Mono I2S transmitter: one holding register fed by valid/ready, each sample sent in
// both the left and right slots, MSB first. Defining I2S_LEFT_JUSTIFIED_EN switches
// from Philips timing (MSB one SCK after WS) to left-justified (MSB aligned with WS).
module i2s_tx_serializer
  import waves_pkg::*;
#(
  parameter int unsigned CLK_DIV  = I2S_CLK_DIV_DEFAULT,
  parameter int unsigned SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       i2s_sck,
  output logic                       i2s_ws,
  output logic                       i2s_sd,
  output logic                       underrun
);

  localparam int unsigned FRAME_W = 2 * SAMPLE_W;
  localparam int unsigned IDX_W   = $clog2(FRAME_W);

`ifdef I2S_LEFT_JUSTIFIED_EN
  localparam logic [IDX_W-1:0] LOAD_IDX   = IDX_W'(0);
  localparam logic [IDX_W-1:0] RELOAD_IDX = IDX_W'(SAMPLE_W);
`else
  localparam logic [IDX_W-1:0] LOAD_IDX   = IDX_W'(1);
  localparam logic [IDX_W-1:0] RELOAD_IDX = IDX_W'(SAMPLE_W + 1);
`endif

  logic                fall_evt;
  logic [IDX_W-1:0]    bit_idx;
  logic [IDX_W-1:0]    next_idx;
  logic [SAMPLE_W-1:0] hold_reg;
  logic                hold_full;
  logic [SAMPLE_W-1:0] last_sample;
  logic [SAMPLE_W-1:0] shift_reg;
  logic [SAMPLE_W-1:0] shift_next;
  logic                load_new;
  logic                reload;
  logic                xfer;

  i2s_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .i2s_sck  (i2s_sck),
    .fall_evt (fall_evt)
  );

  assign sample_ready = ~hold_full;
  assign xfer         = sample_valid & sample_ready;
  assign next_idx     = (bit_idx == IDX_W'(FRAME_W - 1)) ? '0 : bit_idx + 1'b1;
  assign load_new     = fall_evt & (next_idx == LOAD_IDX);
  assign reload       = fall_evt & (next_idx == RELOAD_IDX);

  // Next shift-register contents for a fall event: fresh/repeated sample or plain shift.
  always_comb begin
    shift_next = shift_reg << 1;
    if (load_new) begin
      shift_next = hold_full ? hold_reg : last_sample;
    end else if (reload) begin
      shift_next = last_sample;
    end
  end

  // Holding and last-sample registers; they keep running while en is low.
  // The slot load sees hold_full before any same-edge transfer lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_reg    <= '0;
      hold_full   <= 1'b0;
      last_sample <= '0;
    end else begin
      if (xfer) begin
        hold_reg  <= sample_in;
        hold_full <= 1'b1;
      end else if (load_new && hold_full) begin
        hold_full <= 1'b0;
      end
      if (load_new && hold_full) begin
        last_sample <= hold_reg;
      end
    end
  end

  // One-clk underrun pulse when a frame starts with the holding register empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun <= 1'b0;
    end else begin
      underrun <= load_new & ~hold_full;
    end
  end

  // Frame position, WS and SD; all change on the SCK falling edge.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      bit_idx   <= '0;
      shift_reg <= '0;
      i2s_ws    <= 1'b0;
      i2s_sd    <= 1'b0;
    end else if (fall_evt) begin
      bit_idx   <= next_idx;
      shift_reg <= shift_next;
      i2s_ws    <= (next_idx >= IDX_W'(SAMPLE_W));
      i2s_sd    <= shift_next[SAMPLE_W-1];
    end
  end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench for i2s_tx_serializer (default Philips build, CLK_DIV=8).
module tb_i2s_tx_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        underrun;

  int n_checks = 0;
  int n_pass   = 0;
  int ec       = 0;  // clk edges seen by the stimulus process
  int base     = 0;  // edge at which en/rst was last released
  int fcnt     = 0;  // fall events since base
  int xfers    = 0;

  always #5 clk = ~clk;

  i2s_tx_serializer #(
    .CLK_DIV  (8),
    .SAMPLE_W (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .i2s_sck      (i2s_sck),
    .i2s_ws       (i2s_ws),
    .i2s_sd       (i2s_sd),
    .underrun     (underrun)
  );

  // Handshake transfers, seen with pre-edge values.
  always @(posedge clk) begin
    if (rst_n && sample_valid && sample_ready) xfers <= xfers + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic goto(input int e);
    if (e > ec) begin
      repeat (e - ec) @(posedge clk);
      #1;
      ec = e;
    end
  endtask

  // Walk nfalls SCK falls, checking SCK, WS, SD and underrun at each one.
  task automatic do_frame(input logic [15:0] val, input logic ur, input logic [15:0] nxt,
                          input logic keep_valid, input int nfalls);
    int idx;
    for (int n = 1; n <= nfalls; n++) begin
      fcnt++;
      goto(base + 16 * fcnt);
      idx = (n <= 16) ? 16 - n : 32 - n;
      check("sck_fall", 32'(i2s_sck), 32'd0);
      check("ws", 32'(i2s_ws), 32'((n % 32) >= 16));
      check("sd", 32'(i2s_sd), 32'(val[idx]));
      check("underrun", 32'(underrun), 32'(n == 1 && ur));
      if (n == 1) begin
        sample_in = nxt;
        goto(ec + 1);
        check("underrun_width", 32'(underrun), 32'd0);
        sample_valid = keep_valid;
      end
      goto(base + 16 * fcnt + 8);
      check("sck_rise", 32'(i2s_sck), 32'd1);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sample_in    = 16'h0000;

    // Reset state
    goto(5);
    check("rst_sck", 32'(i2s_sck), 32'd0);
    check("rst_ws", 32'(i2s_ws), 32'd0);
    check("rst_sd", 32'(i2s_sd), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    rst_n = 1'b1;

    // Push one sample while idle
    sample_valid = 1'b1;
    sample_in    = 16'hA5C3;
    goto(ec + 1);
    sample_valid = 1'b0;
    check("ready_full", 32'(sample_ready), 32'd0);
    goto(ec + 3);
    check("idle_sck", 32'(i2s_sck), 32'd0);

    // Frame 1 carries the sample, frame 2 repeats it with underrun
    en   = 1'b1;
    base = ec;
    fcnt = 0;
    do_frame(16'hA5C3, 1'b0, 16'hA5C3, 1'b0, 32);
    check("ready_after_load", 32'(sample_ready), 32'd1);
    check("xfers_1", 32'(xfers), 32'd1);
    do_frame(16'hA5C3, 1'b1, 16'hA5C3, 1'b0, 32);

    // Transfer lands on the load edge: underrun now, value sent next frame
    goto(base + 16 * 65 - 1);
    sample_valid = 1'b1;
    sample_in    = 16'h1234;
    do_frame(16'hA5C3, 1'b1, 16'h1234, 1'b1, 32);
    check("ready_same_edge", 32'(sample_ready), 32'd0);
    check("xfers_2", 32'(xfers), 32'd2);
    do_frame(16'h1234, 1'b0, 16'h1235, 1'b1, 32);
    check("xfers_3", 32'(xfers), 32'd3);
    do_frame(16'h1235, 1'b0, 16'hFF80, 1'b1, 32);
    check("xfers_4", 32'(xfers), 32'd4);

    // Drop en at bit_idx 9 with SCK high and SD high
    do_frame(16'hFF80, 1'b0, 16'h8001, 1'b0, 9);
    check("xfers_5", 32'(xfers), 32'd5);
    check("pre_drop_sd", 32'(i2s_sd), 32'd1);
    en = 1'b0;
    goto(ec + 1);
    check("drop_sck", 32'(i2s_sck), 32'd0);
    check("drop_ws", 32'(i2s_ws), 32'd0);
    check("drop_sd", 32'(i2s_sd), 32'd0);
    check("drop_ready", 32'(sample_ready), 32'd0);
    goto(ec + 20);
    check("drop_idle_sck", 32'(i2s_sck), 32'd0);

    // Re-enable: first fall 16 clks later sends held sample MSB at bit_idx 1
    en   = 1'b1;
    base = ec;
    fcnt = 0;
    goto(base + 15);
    check("reen_sck_high", 32'(i2s_sck), 32'd1);
    check("reen_sd_idle", 32'(i2s_sd), 32'd0);
    do_frame(16'h8001, 1'b0, 16'h8001, 1'b0, 32);
    check("reen_ready", 32'(sample_ready), 32'd1);

    // Reset mid-frame clears everything, including the pending sample
    sample_valid = 1'b1;
    sample_in    = 16'h7777;
    goto(ec + 1);
    sample_valid = 1'b0;
    check("pend_ready", 32'(sample_ready), 32'd0);
    goto(ec + 100);
    rst_n = 1'b0;
    goto(ec + 1);
    check("mrst_sck", 32'(i2s_sck), 32'd0);
    check("mrst_ws", 32'(i2s_ws), 32'd0);
    check("mrst_sd", 32'(i2s_sd), 32'd0);
    check("mrst_underrun", 32'(underrun), 32'd0);
    check("mrst_ready", 32'(sample_ready), 32'd1);
    goto(ec + 2);
    rst_n = 1'b1;
    base  = ec;
    fcnt  = 0;
    do_frame(16'h0000, 1'b1, 16'h0000, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Final output stage of the wave generator: accepts 16-bit signed PCM samples from the waveform/noise mixer over a valid/ready handshake.
- Drives standard Philips I2S pins: SCK on uo_out[0], WS on uo_out[1], SD on uo_out[2].
- Output is mono: each sample is duplicated into the left and right slots.
- Derives SCK from the 25 MHz system clock with an integer divider; 32 SCK periods per frame.

Parameters:
- CLK_DIV, 8: clk cycles per SCK half-period (>=2). Default gives 1.5625 MHz SCK and 48.83 kHz fs.
- SAMPLE_W, 16: sample width and slot width. Frame = 2*SAMPLE_W bits.

Ports:
- clk  input  1  system clock, 25 MHz
- rst_n  input  1  synchronous active-low reset
- en  input  1  serializer enable; 0 = synchronous idle
- sample_in  input  SAMPLE_W  signed PCM sample
- sample_valid  input  1  sample_in is valid
- sample_ready  output  1  holding register empty; accepts a sample this cycle
- i2s_sck  output  1  bit clock
- i2s_ws  output  1  word select; 0 = left, 1 = right
- i2s_sd  output  1  serial data, MSB first
- underrun  output  1  one-clk pulse when a frame starts with no new sample

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: i2s_sck=0, i2s_ws=0, i2s_sd=0, underrun=0, sample_ready=1. Holding register, shift register and last-sample register are cleared to 0; div_cnt=0; bit_idx=0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1 it wraps and i2s_sck toggles.
  - A 1->0 toggle is a "fall event".
- Bit index:
  - On each fall event, bit_idx increments mod 32.
  - i2s_ws and i2s_sd update on the same clk edge as the SCK fall, so there is 0 extra latency.
  - The receiver samples on SCK rise.
- WS: i2s_ws=1 for bit_idx 16..31 and 0 for bit_idx 0..15. It is registered with a one-bit delay, so WS changes one SCK before each slot MSB.
- SD slot mapping:
  - Left MSB is driven at bit_idx=1, left LSB at bit_idx=16.
  - Right MSB at bit_idx=17, right LSB at bit_idx=0 of the next frame.
- Load at fall event with new bit_idx=1:
  - If the holding register is full, it is copied to the shift register and to last-sample, and the holding register becomes empty.
  - If it is empty, last-sample is reused and underrun pulses for exactly one clk.
- Load at new bit_idx=17: last-sample is reloaded into the shift register (mono duplicate).
- Other fall events: the shift register shifts left by 1; i2s_sd = shift MSB.
- Handshake:
  - sample_ready = holding empty.
  - Transfer occurs when sample_valid && sample_ready at a clk edge.
  - If the bit-1 load and an incoming transfer hit the same edge, the load takes the old (empty) state: an underrun is flagged and the new sample is captured into holding for the next frame.
  - sample_in must be stable only in the transfer cycle.
- en=0:
  - Same clk edge: div_cnt, bit_idx, i2s_sck, i2s_ws, i2s_sd return to reset values.
  - Holding register, last-sample and the handshake keep working.
  - On en 0->1 the first fall event occurs 2*CLK_DIV clks later, giving bit_idx=1 (left MSB).
- Reset mid-frame: immediate synchronous return to reset state; no partial frame resumes.

Optional Feature:
- Macro I2S_LEFT_JUSTIFIED_EN.
  - Defined: left-justified format. WS and the MSB align, with no one-bit delay. Left occupies bit_idx 0..15, right 16..31; the load for each slot happens at new bit_idx=0 and bit_idx=16, and underrun is evaluated at bit_idx=0. i2s_ws=1 for bit_idx 16..31.
  - Undefined: Philips I2S as described above.

Decomposition:
- Shared package waves_pkg holds:
  - typedef sample_t (logic signed [15:0])
  - FRAME_BITS=32
  - I2S_CLK_DIV_DEFAULT=8
- One sub-module, i2s_sck_gen: divider plus SCK register. It outputs i2s_sck and a fall_evt strobe, and takes en as a synchronous clear.

Test Plan:
- Reset: hold rst_n=0 for 5 clks -> all outputs 0 and sample_ready=1.
- Period and framing: en=1, no samples -> SCK period 16 clks. WS period 512 clks, high for 256 clks. WS goes 0 at the fall event of bit_idx=0.
- Single frame: push 0xA5C3 once -> SD bits after falls 1..16 read 1010010111000011 and falls 17..32 repeat the same. underrun=0 for that frame.
- Underrun repeat: no further sample -> next frame re-sends 0xA5C3 and underrun pulses exactly one clk at the fall of bit_idx=1.
- Back-pressure and same-edge case: hold sample_valid=1 continuously with an incrementing pattern -> exactly one transfer per 512 clks. A transfer on the bit-1 load edge yields underrun=1 and the value is sent in the following frame.
- Enable/reset mid-frame: drop en at bit_idx=9 -> SCK/WS/SD are 0 next clk. Re-enable -> first fall after 16 clks with WS=0 and SD = MSB of the held sample.
